// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between an initiator and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one RV32I load/store at a time after a fixed wait,
// with byte-lane stores, sign/zero-extended loads and rejection of malformed requests.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nextState;
  logic [3:0]  waitCnt;
  logic        weQ;
  logic [31:0] addrQ;
  logic [2:0]  funct3Q;
  logic [31:0] wdataQ;
  logic [31:0] rdataQ;
  logic        errQ;
  logic [31:0] mem [DEPTH_WORDS];

  logic             handshake;
  logic             enterResp;
  logic             curWe;
  logic [31:0]      curAddr;
  logic [2:0]       curFunct3;
  logic [31:0]      curWdata;
  logic             curErr;
  logic [IDX_W-1:0] curIdx;
  logic [3:0]       byteEn;
  logic [31:0]      storeData;
  logic [31:0]      laneWord;
  logic [31:0]      loadData;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.req_valid) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt <= 4'd1) nextState = RESP;
      RESP:    if (bus.rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    handshake = bus.req_valid && (state == IDLE);
    enterResp = (nextState == RESP) && (state != RESP);
  end

  // With zero wait states the response is formed on the handshake edge itself,
  // so the live bus request is used while IDLE and the latched copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      curWe     = bus.req_we;
      curAddr   = bus.req_addr;
      curFunct3 = bus.req_funct3;
      curWdata  = bus.req_wdata;
    end else begin
      curWe     = weQ;
      curAddr   = addrQ;
      curFunct3 = funct3Q;
      curWdata  = wdataQ;
    end
  end

  always_comb begin
    curErr = 1'b0;
    case (curFunct3)
      3'b000:  curErr = 1'b0;
      3'b001:  curErr = curAddr[0];
      3'b010:  curErr = (curAddr[1:0] != 2'b00);
      3'b100:  curErr = curWe;
      3'b101:  curErr = curWe || curAddr[0];
      default: curErr = 1'b1;
    endcase
    if ({2'b00, curAddr[31:2]} >= DEPTH_WORDS) curErr = 1'b1;

    curIdx    = curAddr[IDX_W+1:2];
    byteEn    = '0;
    storeData = curWdata;
    case (curFunct3[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << curAddr[1:0];
        storeData = {4{curWdata[7:0]}};
      end
      2'b01: begin
        byteEn    = curAddr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{curWdata[15:0]}};
      end
      2'b10:   byteEn = 4'b1111;
      default: byteEn = '0;
    endcase

    laneWord = mem[curIdx] >> {curAddr[1:0], 3'b000};
    case (curFunct3)
      3'b000:  loadData = {{24{laneWord[7]}}, laneWord[7:0]};
      3'b001:  loadData = {{16{laneWord[15]}}, laneWord[15:0]};
      3'b010:  loadData = laneWord;
      3'b100:  loadData = {24'h000000, laneWord[7:0]};
      3'b101:  loadData = {16'h0000, laneWord[15:0]};
      default: loadData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      weQ     <= 1'b0;
      addrQ   <= '0;
      funct3Q <= '0;
      wdataQ  <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      state <= nextState;
      if (handshake) begin
        weQ     <= bus.req_we;
        addrQ   <= bus.req_addr;
        funct3Q <= bus.req_funct3;
        wdataQ  <= bus.req_wdata;
        waitCnt <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (enterResp) begin
        errQ   <= curErr;
        rdataQ <= (curErr || curWe) ? '0 : loadData;
      end
    end
  end

  // Backing store is deliberately left out of reset; the commit is gated by reset instead.
  always_ff @(posedge clk) begin
    if (reset && enterResp && curWe && !curErr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[curIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = (state == RESP) ? rdataQ : '0;
    bus.rsp_err   = (state == RESP) && errQ;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic scored against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bif ();
  data_mem_responder_if bif0 ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bif0)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] refBytes [1024];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic        expErr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, little-endian assembly of loads.
  function automatic void modelTxn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int size;
    logic [31:0] v;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
       || (we && (f3 == 3'b100 || f3 == 3'b101))
       || ((f3 == 3'b001 || f3 == 3'b101) && addr[0])
       || (f3 == 3'b010 && addr[1:0] != 2'b00)
       || ((addr / 4) >= 256);
    rd = '0;
    if (err) return;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) begin
      for (int k = 0; k < size; k++) refBytes[int'(addr) + k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(refBytes[int'(addr) + k]) << (8 * k));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endfunction

  task automatic handshake(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd);
    int n = 0;
    while (!bif.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bif.req_ready) chk("req_ready_timeout", 32'(bif.req_ready), 32'd1);
    bif.req_valid  = 1'b1;
    bif.req_we     = we;
    bif.req_addr   = addr;
    bif.req_funct3 = f3;
    bif.req_wdata  = wd;
    @(posedge clk); #1;
    bif.req_valid  = 1'b0;
    bif.req_we     = 1'($urandom_range(0, 1));
    bif.req_addr   = $urandom;
    bif.req_funct3 = 3'($urandom_range(0, 7));
    bif.req_wdata  = $urandom;
  endtask

  task automatic doTxn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input int hold,
                       output logic err, output logic [31:0] rd);
    int lat;
    logic ok;
    logic e0;
    logic [31:0] d0;
    handshake(we, addr, f3, wd);
    lat = 1;
    ok  = 1'b1;
    while (!bif.rsp_valid && lat < 40) begin
      ok = ok && !bif.req_ready;
      bif.rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    bif.rsp_ready = 1'b0;
    chk("latency", 32'(lat), 32'(WS + 1));
    chk("busy_not_ready", 32'(ok), 32'd1);
    e0 = bif.rsp_err;
    d0 = bif.rsp_rdata;
    ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      ok = ok && bif.rsp_valid && !bif.req_ready && (bif.rsp_err == e0) && (bif.rsp_rdata == d0);
    end
    if (hold > 0) chk("backpressure_hold", 32'(ok), 32'd1);
    bif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif.rsp_ready = 1'b0;
    chk("release_to_idle", 32'({bif.rsp_valid, bif.req_ready}), 32'b01);
    err = e0;
    rd  = d0;
  endtask

  task automatic zwTxn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] expData);
    bif0.req_valid  = 1'b1;
    bif0.req_we     = we;
    bif0.req_addr   = addr;
    bif0.req_funct3 = f3;
    bif0.req_wdata  = wd;
    @(posedge clk); #1;
    bif0.req_valid  = 1'b0;
    chk("zw_valid_next_cycle", 32'({bif0.rsp_valid, bif0.req_ready, bif0.rsp_err}), 32'b100);
    chk("zw_rdata", bif0.rsp_rdata, expData);
    bif0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bif0.rsp_ready = 1'b0;
    chk("zw_idle", 32'({bif0.rsp_valid, bif0.req_ready}), 32'b01);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e, me;
    logic [31:0] d, md;
    int n;

    vecs[0]  = '{1'b1, 32'h010, 3'b010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 32'h010, 3'b010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h011, 3'b000, 32'h55667780, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h010, 3'b010, 32'h0,        1'b0, 32'hDEAD80EF};
    vecs[4]  = '{1'b0, 32'h011, 3'b000, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[5]  = '{1'b0, 32'h011, 3'b100, 32'h0,        1'b0, 32'h00000080};
    vecs[6]  = '{1'b0, 32'h012, 3'b101, 32'h0,        1'b0, 32'h0000DEAD};
    vecs[7]  = '{1'b0, 32'h012, 3'b001, 32'h0,        1'b0, 32'hFFFFDEAD};
    vecs[8]  = '{1'b0, 32'h013, 3'b010, 32'h0,        1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 32'h011, 3'b001, 32'h0000FFFF, 1'b1, 32'h00000000};
    vecs[10] = '{1'b0, 32'h010, 3'b010, 32'h0,        1'b0, 32'hDEAD80EF};
    vecs[11] = '{1'b0, 32'h400, 3'b010, 32'h0,        1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 32'h010, 3'b011, 32'h0,        1'b1, 32'h00000000};
    vecs[13] = '{1'b1, 32'h3FC, 3'b010, 32'hCAFEF00D, 1'b0, 32'h00000000};
    vecs[14] = '{1'b0, 32'h3FC, 3'b010, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 32'h3FF, 3'b000, 32'h00000011, 1'b0, 32'h00000000};
    vecs[16] = '{1'b0, 32'h3FE, 3'b101, 32'h0,        1'b0, 32'h000011FE};
    vecs[17] = '{1'b1, 32'h400, 3'b010, 32'h01020304, 1'b1, 32'h00000000};
    vecs[18] = '{1'b0, 32'h3FF, 3'b100, 32'h0,        1'b0, 32'h00000011};
    vecs[19] = '{1'b0, 32'h013, 3'b000, 32'h0,        1'b0, 32'hFFFFFFDE};
    vecs[20] = '{1'b0, 32'h011, 3'b101, 32'h0,        1'b1, 32'h00000000};

    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_funct3 = '0;
    bif.req_wdata = '0;   bif.rsp_ready = 1'b0;
    bif0.req_valid = 1'b0; bif0.req_we = 1'b0; bif0.req_addr = '0; bif0.req_funct3 = '0;
    bif0.req_wdata = '0;   bif0.rsp_ready = 1'b0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'({bif.req_ready, bif.rsp_valid, bif.rsp_err}), 32'b100);
    chk("reset_rdata", bif.rsp_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'({bif.req_ready, bif0.req_ready}), 32'b11);

    for (int i = 0; i < 21; i++) begin
      doTxn(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, 0, e, d);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].expErr));
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].expData);
    end

    doTxn(1'b0, 32'h010, 3'b010, 32'h0, 5, e, d);
    chk("bp_rdata", d, 32'hDEAD80EF);

    // Reset one cycle into WAIT of a store: store must be dropped.
    doTxn(1'b1, 32'h020, 3'b010, 32'h0BADF00D, 0, e, d);
    handshake(1'b1, 32'h020, 3'b010, 32'h12345678);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_flags", 32'({bif.req_ready, bif.rsp_valid, bif.rsp_err}), 32'b100);
    chk("rst_wait_rdata", bif.rsp_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    doTxn(1'b0, 32'h020, 3'b010, 32'h0, 0, e, d);
    chk("rst_wait_no_store", d, 32'h0BADF00D);

    // Reset while a committed store's response is pending: data stays.
    handshake(1'b1, 32'h024, 3'b010, 32'h11223344);
    n = 0;
    while (!bif.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_resp_reached", 32'(bif.rsp_valid), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_dropped", 32'({bif.rsp_valid, bif.req_ready}), 32'b01);
    reset = 1'b1;
    @(posedge clk); #1;
    doTxn(1'b0, 32'h024, 3'b010, 32'h0, 0, e, d);
    chk("rst_resp_kept", d, 32'h11223344);

    zwTxn(1'b1, 32'h000, 3'b010, 32'hA5A55A5A, 32'h0);
    zwTxn(1'b0, 32'h000, 3'b010, 32'h0, 32'hA5A55A5A);
    zwTxn(1'b0, 32'h002, 3'b001, 32'h0, 32'hFFFFA5A5);

    for (int w = 0; w < 8; w++) begin
      d = $urandom;
      modelTxn(1'b1, 32'(w * 4), 3'b010, d, me, md);
      doTxn(1'b1, 32'(w * 4), 3'b010, d, 0, e, md);
    end
    for (int i = 0; i < 150; i++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] raddr, rwd;
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                          : 32'($urandom_range(0, 31));
      rwd   = $urandom;
      modelTxn(rwe, raddr, rf3, rwd, me, md);
      doTxn(rwe, raddr, rf3, rwd, $urandom_range(0, 2), e, d);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
      chk($sformatf("rnd%0d_rdata", i), d, md);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the backing store.
REQ-002 Parameter WAIT_STATES, default 2: cycles spent in WAIT before a response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response is valid.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 rsp_err  output  1  request was rejected; no memory side effect.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE. Handshake: req_valid & req_ready at a rising edge.
REQ-017 On handshake the block SHALL latch we, addr, funct3 and wdata, then go to WAIT. If WAIT_STATES = 0 it SHALL go directly to RESP.
REQ-018 WAIT SHALL count WAIT_STATES cycles with a 4-bit down-counter, then go to RESP.
- rsp_valid first rises WAIT_STATES+1 cycles after the handshake edge.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_valid & rsp_ready at an edge, which returns the FSM to IDLE.
- No back-to-back acceptance: at least one IDLE cycle between responses.
REQ-020 An error SHALL be flagged in any of these cases:
- funct3 is 011, 110 or 111;
- a store with funct3 of 100 or 101;
- H/HU with addr[0] = 1;
- W with addr[1:0] ≠ 0;
- addr[31:2] ≥ DEPTH_WORDS.
REQ-021 On error: rsp_err = 1, rsp_rdata = 0, memory unchanged.
REQ-022 A valid store SHALL update only the addressed byte lanes, exactly once, on the edge entering RESP. For a store: rsp_rdata = 0, rsp_err = 0.
REQ-023 Load data SHALL be read from the word addr[31:2] and the lane selected by addr[1:0].
- B/H: sign-extended.
- BU/HU: zero-extended.
- W: unchanged.
REQ-024 Request inputs SHALL be ignored outside the handshake. Changes while in WAIT/RESP do not affect the latched request.
REQ-025 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-026 While reset = 0 at an edge, the block SHALL set:
- state = IDLE;
- wait counter = 0;
- req_ready = 1, from the first cycle after reset deasserts;
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset during WAIT SHALL abort the pending request and perform no store.
REQ-029 Reset during RESP SHALL drop the response; a store already committed remains in memory.

Verification
REQ-030 Word round trip, WAIT_STATES = 2:
- SW addr 0x10 data 0xDEADBEEF -> rsp_valid 3 cycles after the handshake, err = 0.
- Then LW 0x10 -> rsp_rdata = 0xDEADBEEF.
REQ-031 Byte lanes and extension (memory word 0x10 = 0xDEADBEEF):
- SB addr 0x11 data 0x80 -> word 0x10 = 0xDEAD80EF.
- LB 0x11 -> 0xFFFFFF80.
- LBU 0x11 -> 0x00000080.
- LHU 0x12 -> 0x0000DEAD.
REQ-032 Errors:
- LW 0x13 -> rsp_err = 1, rdata = 0.
- SH 0x11 -> rsp_err = 1, memory unchanged.
- LW 0x400 with DEPTH_WORDS = 256 -> rsp_err = 1.
- funct3 = 011 -> rsp_err = 1.
REQ-033 Backpressure: hold rsp_ready = 0 for 5 cycles in RESP.
- rsp_valid stays 1 with stable data; req_ready stays 0.
- After rsp_ready = 1, one edge later the block is in IDLE with req_ready = 1.
REQ-034 Zero wait, WAIT_STATES = 0: LW -> rsp_valid asserted the cycle after the handshake.
REQ-035 Reset mid-operation:
- Assert reset 1 cycle into WAIT of SW 0x20 data 0x12345678 -> outputs return to reset values.
- A subsequent LW 0x20 returns the pre-existing value, not 0x12345678.
